// File: rtl/video_capture_sink.sv
// Frame-capture requester: issues {row, chunk} requests upstream, drains the
// returned pixels through a two-entry skid buffer and writes them to a linear
// framebuffer through a ready/valid memory write port.
module video_capture_sink #(
  parameter int CHUNK_BITS      = 5,
  parameter int HACTIVE_BITS    = 11,
  parameter int VACTIVE_BITS    = 11,
  parameter int BITS_PER_PIXEL  = 16,
  parameter int ADDR_BITS       = 22,
  parameter int MAX_OUTSTANDING = 2,
  localparam int CHUNKNUM_BITS  = HACTIVE_BITS - CHUNK_BITS,
  localparam int REQUEST_BITS   = VACTIVE_BITS + CHUNKNUM_BITS
) (
  input  logic                      scalerClock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [VACTIVE_BITS-1:0]   frameRows,
  input  logic [CHUNKNUM_BITS-1:0]  frameChunks,
  input  logic [ADDR_BITS-1:0]      baseAddress,
  input  logic [ADDR_BITS-1:0]      lineStride,
  output logic                      requestFifoWriteEnable,
  input  logic                      requestFifoFull,
  output logic [REQUEST_BITS-1:0]   requestFifoWriteData,
  output logic                      responseFifoReadEnable,
  input  logic                      responseFifoEmpty,
  input  logic [BITS_PER_PIXEL-1:0] responseFifoReadData,
  output logic                      memWriteEnable,
  input  logic                      memReady,
  output logic [ADDR_BITS-1:0]      memAddress,
  output logic [BITS_PER_PIXEL-1:0] memWriteData,
  output logic                      busy,
  output logic                      frameDone
);

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  // EMPTY gives a zero-sized frame its single busy cycle before frameDone,
  // so DONE always means "frameDone is showing this cycle".
  typedef enum logic [1:0] {IDLE, RUN, EMPTY, DONE} state_t;
  state_t state;

  logic [VACTIVE_BITS-1:0]   last_row;
  logic [CHUNKNUM_BITS-1:0]  last_chunk;
  logic [ADDR_BITS-1:0]      cfg_stride;

  logic [VACTIVE_BITS-1:0]   req_row;
  logic [CHUNKNUM_BITS-1:0]  req_chunk;
  logic                      req_left;
  logic [2:0]                outstanding;

  logic [VACTIVE_BITS-1:0]   wr_row;
  logic [CHUNKNUM_BITS-1:0]  wr_chunk;
  logic [CHUNK_BITS-1:0]     wr_pix;
  logic [ADDR_BITS-1:0]      row_base;
  logic [ADDR_BITS-1:0]      mem_addr;

  logic [BITS_PER_PIXEL-1:0] skid [2];
  logic                      head;
  logic                      tail;
  logic [1:0]                fill;
  logic                      rd_pending;
  logic                      busy_q;
  logic                      done_q;

  logic                      req_fire;
  logic                      rd_fire;
  logic                      accept;
  logic                      chunk_end;
  logic                      row_end;
  logic                      frame_end;
  logic [1:0]                occ;

  // Handshake qualification for the request strobe, response reads and memory writes.
  always_comb begin
    accept    = (fill != 2'd0) && memReady;
    chunk_end = (wr_pix == '1);
    row_end   = chunk_end && (wr_chunk == last_chunk);
    frame_end = row_end && (wr_row == last_row);
    occ       = fill + {1'b0, rd_pending};
    req_fire  = (state == RUN) && req_left && !requestFifoFull && (outstanding < MAX_OUT);
    rd_fire   = (state == RUN) && !responseFifoEmpty &&
                ((occ < 2'd2) || ((occ == 2'd2) && accept));
  end

  assign requestFifoWriteEnable = req_fire;
  assign requestFifoWriteData   = {req_row, req_chunk};
  assign responseFifoReadEnable = rd_fire;
  assign memWriteEnable         = (fill != 2'd0);
  assign memAddress             = mem_addr;
  assign memWriteData           = skid[head];
  assign busy                   = busy_q;
  assign frameDone              = done_q;

  // Frame sequencing, request issue, outstanding tracking and write addressing.
  always_ff @(posedge scalerClock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_row    <= '0;
      last_chunk  <= '0;
      cfg_stride  <= '0;
      req_row     <= '0;
      req_chunk   <= '0;
      req_left    <= 1'b0;
      outstanding <= '0;
      wr_row      <= '0;
      wr_chunk    <= '0;
      wr_pix      <= '0;
      row_base    <= '0;
      mem_addr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_row    <= frameRows - VACTIVE_BITS'(1);
            last_chunk  <= frameChunks - CHUNKNUM_BITS'(1);
            cfg_stride  <= lineStride;
            row_base    <= baseAddress;
            mem_addr    <= baseAddress;
            req_row     <= '0;
            req_chunk   <= '0;
            req_left    <= 1'b1;
            outstanding <= '0;
            wr_row      <= '0;
            wr_chunk    <= '0;
            wr_pix      <= '0;
            busy_q      <= 1'b1;
            state       <= (frameRows == '0 || frameChunks == '0) ? EMPTY : RUN;
          end
        end
        RUN: begin
          if (req_fire) begin
            if (req_chunk == last_chunk) begin
              req_chunk <= '0;
              if (req_row == last_row) req_left <= 1'b0;
              else                     req_row  <= req_row + VACTIVE_BITS'(1);
            end else begin
              req_chunk <= req_chunk + CHUNKNUM_BITS'(1);
            end
          end
          case ({req_fire, accept && chunk_end})
            2'b10:   outstanding <= outstanding + 3'd1;
            2'b01:   outstanding <= outstanding - 3'd1;
            default: outstanding <= outstanding;
          endcase
          if (accept) begin
            wr_pix <= wr_pix + CHUNK_BITS'(1);
            if (row_end) begin
              wr_chunk <= '0;
              wr_row   <= wr_row + VACTIVE_BITS'(1);
              row_base <= row_base + cfg_stride;
              mem_addr <= row_base + cfg_stride;
            end else begin
              if (chunk_end) wr_chunk <= wr_chunk + CHUNKNUM_BITS'(1);
              mem_addr <= mem_addr + ADDR_BITS'(1);
            end
            if (frame_end) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        EMPTY: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry skid buffer between the response FIFO and the memory port.
  always_ff @(posedge scalerClock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 2; i++) skid[i] <= '0;
      head       <= 1'b0;
      tail       <= 1'b0;
      fill       <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= rd_fire;
      if (rd_pending) begin
        skid[tail] <= responseFifoReadData;
        tail       <= ~tail;
      end
      if (accept) head <= ~head;
      fill <= fill + {1'b0, rd_pending} - {1'b0, accept};
    end
  end

endmodule

// File: tb/tb_video_capture_sink.sv
// Self-checking bench for video_capture_sink: models the upstream request and
// response FIFOs plus a source, and predicts every request and pixel write.
module tb_video_capture_sink;

  localparam int CB   = 5;
  localparam int HB   = 11;
  localparam int VB   = 11;
  localparam int BPP  = 16;
  localparam int AB   = 22;
  localparam int MAXO = 2;
  localparam int CNB  = HB - CB;
  localparam int RB   = VB + CNB;
  localparam longint AMASK = (64'd1 << AB) - 1;
  localparam int CPIX = 1 << CB;

  logic           scalerClock = 1'b0;
  logic           reset;
  logic           start;
  logic [VB-1:0]  frameRows;
  logic [CNB-1:0] frameChunks;
  logic [AB-1:0]  baseAddress;
  logic [AB-1:0]  lineStride;
  logic           requestFifoWriteEnable;
  logic           requestFifoFull;
  logic [RB-1:0]  requestFifoWriteData;
  logic           responseFifoReadEnable;
  logic           responseFifoEmpty;
  logic [BPP-1:0] responseFifoReadData;
  logic           memWriteEnable;
  logic           memReady;
  logic [AB-1:0]  memAddress;
  logic [BPP-1:0] memWriteData;
  logic           busy;
  logic           frameDone;

  video_capture_sink #(
    .CHUNK_BITS(CB), .HACTIVE_BITS(HB), .VACTIVE_BITS(VB),
    .BITS_PER_PIXEL(BPP), .ADDR_BITS(AB), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .scalerClock(scalerClock), .reset(reset), .start(start),
    .frameRows(frameRows), .frameChunks(frameChunks),
    .baseAddress(baseAddress), .lineStride(lineStride),
    .requestFifoWriteEnable(requestFifoWriteEnable), .requestFifoFull(requestFifoFull),
    .requestFifoWriteData(requestFifoWriteData),
    .responseFifoReadEnable(responseFifoReadEnable), .responseFifoEmpty(responseFifoEmpty),
    .responseFifoReadData(responseFifoReadData),
    .memWriteEnable(memWriteEnable), .memReady(memReady),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .busy(busy), .frameDone(frameDone)
  );

  always #5 scalerClock = ~scalerClock;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int     rows;
    int     chunks;
    longint base;
    longint stride;
    int     rmode;
    int     gmode;
    bit     full_win;
    bit     busy_start;
    int     exp_writes;
    longint exp_first;
    longint exp_last;
  } vec_t;

  // Upstream model and frame expectations
  logic [RB-1:0]  req_q[$];
  logic [RB-1:0]  exp_req[$];
  logic [BPP-1:0] resp_q[$];
  logic [BPP-1:0] exp_data[$];
  int     ready_mode = 0;
  int     gap_mode   = 0;
  bit     force_full = 1'b0;
  bit     frame_active = 1'b0;
  longint m_base, m_stride;
  int     m_rows, m_chunks;
  int     frame_writes = 0;
  int     frame_reqs = 0;
  int     done_count = 0;
  int     outstanding_m = 0;
  int     first_req = -1;
  longint first_addr = 0;
  longint last_addr = 0;

  initial begin : model
    bit             ev_req, ev_rd, prev_we, prev_rdy, prev_final, now_final;
    logic [RB-1:0]  ev_req_data, rq;
    logic [AB-1:0]  prev_addr;
    logic [BPP-1:0] prev_data;
    longint         k, per_row, exp_addr;
    int unsigned    cyc;
    cyc = 0; prev_we = 0; prev_rdy = 0; prev_final = 0;
    prev_addr = '0; prev_data = '0;
    requestFifoFull = 1'b0; responseFifoEmpty = 1'b1;
    responseFifoReadData = '0; memReady = 1'b0;
    forever begin
      @(negedge scalerClock);
      ev_req = 0; ev_rd = 0; now_final = 0; ev_req_data = '0;
      if (!reset) begin
        check_eq("reset_outputs",
                 longint'({requestFifoWriteEnable, requestFifoWriteData, responseFifoReadEnable,
                           memWriteEnable, memAddress, memWriteData, busy, frameDone}), 0);
        req_q.delete(); resp_q.delete(); exp_data.delete(); exp_req.delete();
        frame_active = 0; outstanding_m = 0; prev_we = 0; prev_final = 0;
      end else begin
        if (start && !busy) begin
          m_rows = int'(frameRows); m_chunks = int'(frameChunks);
          m_base = longint'(baseAddress); m_stride = longint'(lineStride);
          exp_req.delete();
          for (int r = 0; r < m_rows; r++)
            for (int c = 0; c < m_chunks; c++)
              exp_req.push_back(RB'((r << CNB) | c));
          frame_active = 1; frame_writes = 0; frame_reqs = 0; done_count = 0;
          outstanding_m = 0; first_req = -1;
        end
        if (requestFifoFull) check_eq("req_while_full", requestFifoWriteEnable, 0);
        if (requestFifoWriteEnable) begin
          ev_req = 1; ev_req_data = requestFifoWriteData;
          check_eq("outstanding_limit", outstanding_m < MAXO, 1);
          check_eq("request_in_frame", exp_req.size() > 0, 1);
          if (exp_req.size() > 0) begin
            rq = exp_req.pop_front();
            check_eq("request_data", requestFifoWriteData, rq);
          end
          if (frame_reqs == 0) first_req = int'(requestFifoWriteData);
          frame_reqs++; outstanding_m++;
        end
        if (responseFifoReadEnable) begin
          check_eq("read_while_empty", responseFifoEmpty, 0);
          ev_rd = !responseFifoEmpty && resp_q.size() > 0;
        end
        if (prev_we && !prev_rdy)
          check_eq("stall_hold", {memWriteEnable, memAddress, memWriteData},
                   {1'b1, prev_addr, prev_data});
        if (memWriteEnable && memReady) begin
          k = frame_writes;
          per_row = longint'(m_chunks) * CPIX;
          exp_addr = per_row == 0 ? 0 :
                     (m_base + (k / per_row) * m_stride + (k % per_row)) & AMASK;
          check_eq("mem_address", memAddress, exp_addr);
          check_eq("write_in_frame", exp_data.size() > 0, 1);
          if (exp_data.size() > 0) check_eq("mem_data", memWriteData, exp_data.pop_front());
          if (frame_writes == 0) first_addr = memAddress;
          last_addr = memAddress;
          frame_writes++;
          if (frame_writes % CPIX == 0) outstanding_m--;
          if (frame_writes == m_rows * m_chunks * CPIX) now_final = 1;
        end
        if (frameDone) begin
          check_eq("done_in_frame", frame_active, 1);
          check_eq("done_writes", frame_writes, m_rows * m_chunks * CPIX);
          check_eq("done_busy_low", busy, 0);
          check_eq("done_all_requests", exp_req.size(), 0);
          if (m_rows * m_chunks > 0) check_eq("done_timing", prev_final, 1);
          done_count++;
          frame_active = 0;
        end
        prev_final = now_final;
        prev_we = memWriteEnable; prev_rdy = memReady;
        prev_addr = memAddress; prev_data = memWriteData;
      end
      @(posedge scalerClock); #1;
      cyc++;
      if (ev_rd) responseFifoReadData = resp_q.pop_front();
      if (ev_req) req_q.push_back(ev_req_data);
      if (req_q.size() > 0 && resp_q.size() < 48 && (gap_mode == 0 || $urandom_range(0, 2) != 0)) begin
        void'(req_q.pop_front());
        for (int p = 0; p < CPIX; p++) begin
          logic [BPP-1:0] px;
          px = BPP'($urandom);
          resp_q.push_back(px);
          exp_data.push_back(px);
        end
      end
      responseFifoEmpty = (resp_q.size() == 0) || (gap_mode != 0 && $urandom_range(0, 3) == 0);
      requestFifoFull = force_full || (req_q.size() >= 4);
      case (ready_mode)
        0:       memReady = 1'b1;
        1:       memReady = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: memReady = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic tick();
    @(posedge scalerClock); #2;
  endtask

  task automatic run_frame(input vec_t v);
    ready_mode = v.rmode; gap_mode = v.gmode;
    frameRows = VB'(v.rows); frameChunks = CNB'(v.chunks);
    baseAddress = AB'(v.base); lineStride = AB'(v.stride);
    start = 1'b1; tick(); start = 1'b0;
    if (v.full_win) begin
      for (int i = 0; i < 2000 && frame_reqs < 3; i++) tick();
      force_full = 1'b1;
      repeat (20) tick();
      force_full = 1'b0;
    end
    if (v.busy_start) begin
      for (int i = 0; i < 2000 && frame_writes < 10; i++) tick();
      frameRows = VB'(5); frameChunks = CNB'(7); baseAddress = '0;
      start = 1'b1; tick(); start = 1'b0;
    end
    for (int i = 0; i < 6000 && done_count == 0; i++) tick();
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    run_frame(v);
    check_eq({tag, "_done"}, done_count, 1);
    check_eq({tag, "_writes"}, frame_writes, v.exp_writes);
    check_eq({tag, "_first_addr"}, first_addr, v.exp_first);
    check_eq({tag, "_last_addr"}, last_addr, v.exp_last);
  endtask

  vec_t vecs[5];

  initial begin : main
    vec_t rv;
    //         rows chunks base      stride rm gm full busy writes first     last
    vecs[0] = '{2, 3, 'h100,    'h80,  0, 0, 0, 0, 192, 'h100,    'h1DF};
    vecs[1] = '{2, 3, 'h100,    'h80,  0, 0, 1, 0, 192, 'h100,    'h1DF};
    vecs[2] = '{1, 3, 'h2000,   'h100, 1, 0, 0, 0, 96,  'h2000,   'h205F};
    vecs[3] = '{2, 2, 'h3FFFF0, 'h40,  2, 0, 0, 1, 128, 'h3FFFF0, 'h6F};
    vecs[4] = '{3, 1, 'h5,      'h20,  2, 1, 0, 0, 96,  'h5,      'h64};

    reset = 1'b0; start = 1'b0;
    frameRows = '0; frameChunks = '0; baseAddress = '0; lineStride = '0;
    repeat (3) @(posedge scalerClock);
    #2 reset = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 5; v++) apply_vec($sformatf("vec%0d", v), vecs[v]);

    // Zero-row frame: one busy cycle, then frameDone, no traffic
    ready_mode = 0; gap_mode = 0;
    frameRows = '0; frameChunks = CNB'(3); baseAddress = AB'('h10); lineStride = AB'('h10);
    start = 1'b1; tick(); start = 1'b0;
    @(negedge scalerClock);
    check_eq("zero_busy_first", busy, 1);
    check_eq("zero_done_first", frameDone, 0);
    @(negedge scalerClock);
    check_eq("zero_busy_second", busy, 0);
    check_eq("zero_done_second", frameDone, 1);
    @(negedge scalerClock);
    check_eq("zero_done_third", frameDone, 0);
    check_eq("zero_requests", frame_reqs, 0);
    tick();

    // Randomized frames
    for (int n = 0; n < 4; n++) begin
      rv.rows = $urandom_range(1, 3); rv.chunks = $urandom_range(1, 4);
      rv.base = longint'($urandom) & AMASK; rv.stride = longint'($urandom) & AMASK;
      rv.rmode = 2; rv.gmode = 1; rv.full_win = 0; rv.busy_start = 0;
      rv.exp_writes = rv.rows * rv.chunks * CPIX;
      rv.exp_first = rv.base;
      rv.exp_last = (rv.base + (rv.rows - 1) * rv.stride + rv.chunks * CPIX - 1) & AMASK;
      apply_vec($sformatf("rand%0d", n), rv);
    end

    // Reset in the middle of a frame, then a fresh capture
    ready_mode = 0; gap_mode = 0;
    frameRows = VB'(2); frameChunks = CNB'(3); baseAddress = AB'('h100); lineStride = AB'('h80);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 2000 && frame_writes < 40; i++) tick();
    check_eq("abort_reached_pixel40", frame_writes, 40);
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    check_eq("abort_no_done", done_count, 0);
    rv = '{1, 2, 'h40, 'h0, 0, 0, 0, 0, 64, 'h40, 'h7F};
    apply_vec("after_abort", rv);
    check_eq("after_abort_first_req", first_req, 0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/video_capture_sink.md
Name: video_capture_sink

Overview:
- Requester-side pipeline element: the opposite end of the chunk request/response protocol from a source element.
- Writes {row, chunk} requests into the upstream request FIFO and drains the pixels returned in the response FIFO.
- Writes each pixel to a linear framebuffer via a simple ready/valid memory write port.
- Sits downstream of a filter (e.g. the aggregate scaler) in place of the timing sink, for frame capture and scaler verification.

Parameters:
- CHUNK_BITS, 5: log2 of pixels per chunk.
- HACTIVE_BITS, 11: column counter width.
- VACTIVE_BITS, 11: row counter width.
- BITS_PER_PIXEL, 16: pixel width.
- ADDR_BITS, 22: framebuffer pixel-address width.
- MAX_OUTSTANDING, 2: maximum requests issued but not fully written to memory (1..7).
- Derived: CHUNKNUM_BITS = HACTIVE_BITS-CHUNK_BITS; REQUEST_BITS = VACTIVE_BITS+CHUNKNUM_BITS.

Ports:
- scalerClock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame capture.
- frameRows  in  VACTIVE_BITS  rows to capture; latched at start.
- frameChunks  in  CHUNKNUM_BITS  chunks per row; latched at start.
- baseAddress  in  ADDR_BITS  pixel address of row 0, chunk 0; latched at start.
- lineStride  in  ADDR_BITS  pixel-address distance between rows; latched at start.
- requestFifoWriteEnable  out  1  request write strobe.
- requestFifoFull  in  1  request FIFO full.
- requestFifoWriteData  out  REQUEST_BITS  {row[VACTIVE_BITS-1:0], chunk[CHUNKNUM_BITS-1:0]}.
- responseFifoReadEnable  out  1  response read strobe.
- responseFifoEmpty  in  1  response FIFO empty.
- responseFifoReadData  in  BITS_PER_PIXEL  pixel, valid the cycle after responseFifoReadEnable.
- memWriteEnable  out  1  memory write valid.
- memReady  in  1  memory accepts the write at this edge.
- memAddress  out  ADDR_BITS  pixel address.
- memWriteData  out  BITS_PER_PIXEL  pixel data.
- busy  out  1  capture in progress.
- frameDone  out  1  one-cycle pulse when the last pixel is accepted by memory.

Behaviour:
- Reset (asynchronous, reset low): every output 0; all counters and the skid buffer cleared; state IDLE. FIFO contents are not flushed (the pipeline owns the FIFOs).
- States:
  - IDLE: on start, latch the configuration and set busy=1 at the next edge. If frameRows==0 or frameChunks==0, go to DONE instead.
  - RUN: request issue and response drain operate concurrently.
  - DONE: frameDone=1 for one cycle, busy=0, then IDLE.
- start is ignored while busy=1.
- Request issue:
  - Order: row-major; chunk 0..frameChunks-1 within row, row 0..frameRows-1.
  - requestFifoWriteEnable may be high only when requestFifoFull is low in the same cycle, outstanding < MAX_OUTSTANDING, and requests remain. The write takes effect at that edge.
  - requestFifoWriteData is stable whenever the strobe is high.
- Outstanding counter:
  - +1 on request write; -1 when the last pixel of a chunk is accepted by memory.
  - Both events in the same cycle leave it unchanged.
  - It never exceeds MAX_OUTSTANDING and never underflows.
- Response drain:
  - Uses a 2-entry skid buffer.
  - responseFifoReadEnable=1 only when responseFifoEmpty=0 and (buffered entries + in-flight reads) < 2, or == 2 with a memory acceptance this cycle.
  - Never read while empty.
  - Sustains 1 pixel/cycle with memReady held high.
- Memory port:
  - memWriteEnable high while the buffer is non-empty.
  - memAddress and memWriteData are held stable until memReady=1 at an edge.
  - memWriteEnable may fall only after acceptance.
- Addressing:
  - Pixels are written in response order: row-major, pixel 0..2^CHUNK_BITS-1 within each chunk.
  - Address = baseAddress + row*lineStride + chunk*2^CHUNK_BITS + pixel, modulo 2^ADDR_BITS.
  - Computed incrementally with adders (rowBase += lineStride per row); no multiplier.
- Completion: the cycle after the last pixel of the last chunk is accepted, go to DONE. frameDone asserts exactly once per started frame.
- Reset mid-frame: capture aborts immediately, outputs return to 0, and no frameDone is produced.

Test Plan:
- Basic frame: CHUNK_BITS=5, frameRows=2, frameChunks=3, baseAddress=0x100, lineStride=0x80, memReady=1, responses always available → requests {0,0},{0,1},{0,2},{1,0},{1,1},{1,2}; 192 writes with addresses 0x100-0x15F then 0x180-0x1DF and data matching FIFO order; one frameDone.
- requestFifoFull held high 20 cycles mid-frame → no request strobe during that window; outstanding never exceeds 2; resumes with the next chunk, none skipped or duplicated.
- memReady toggling 1,0,0,1 repeatedly → memAddress and memWriteData constant while stalled; no read when the buffer is full; all 96 pixels of a 1x3 frame written exactly once.
- frameRows=0 with start → no requests, no reads, busy high one cycle, frameDone the following cycle.
- Reset low at pixel 40 of frame 1, then a new start → all outputs 0 during reset; the second frame's first request is {0,0}; no frameDone from the aborted frame.
- baseAddress=0x3FFFF0 with ADDR_BITS=22 → addresses wrap 0x3FFFFF to 0x000000; a start pulse during busy has no effect.
